// File: rtl/rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// RrArbiter4 : four-way round-robin arbiter for one shared downstream resource.
//
// A grant is held until the owner asserts done, drops its request, or has held
// the resource for MAX_HOLD cycles. One IDLE cycle always separates two
// consecutive grants. The next search starts just after the most recent owner.
//
// Parameters
//   MAX_HOLD  maximum grant length in cycles (2..256)
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   4  request lines, req[i] = requester i wants the resource
//   done     in   1  current owner has finished (ignored while idle)
//   gnt      out  4  registered one-hot grant, gnt[i] = busy & (owner == i)
//   owner    out  2  index of current / most recent owner (decoder {a,b})
//   busy     out  1  a grant is active (decoder enable)
//   expired  out  1  one-cycle pulse after a grant was released by timeout
// ---------------------------------------------------------------------------
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       expired
);

  // Counter width; a floor of one bit keeps the vector legal for any MAX_HOLD.
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [1:0]    r_last;
  logic [1:0]    r_owner;
  logic [CW-1:0] r_hold;
  logic [3:0]    r_gnt;
  logic          r_busy;
  logic          r_expired;

  logic [1:0]    w_sel;
  logic          w_found;
  logic          w_ownerReq;
  logic          w_timeout;
  logic          w_release;

  // Rotating priority search: scan last+1 .. last+4, the first requester wins.
  // Offset 4 wraps to the previous owner itself, which therefore has the lowest
  // priority.
  always_comb begin
    logic [1:0] idx;
    w_sel   = 2'd0;
    w_found = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!w_found && req[idx]) begin
        w_sel   = idx;
        w_found = 1'b1;
      end
    end
  end

  // Release causes in priority order: done, request drop, then timeout.
  always_comb begin
    w_ownerReq = req[r_owner];
    w_timeout  = (r_hold == HOLD_LAST);
    w_release  = done || !w_ownerReq || w_timeout;
  end

  // Main state register. Outputs are registered here as well, so no path
  // exists from req or done to any output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 2'd3;
      r_owner   <= 2'd0;
      r_hold    <= '0;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // The timeout pulse only lives for a single idle cycle.
          r_expired <= 1'b0;
          if (w_found) begin
            r_state <= GRANT;
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_hold  <= '0;
            r_gnt   <= 4'b0001 << w_sel;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state   <= IDLE;
            r_gnt     <= 4'b0000;
            r_busy    <= 1'b0;
            // Only a pure timeout is reported; done or a drop take precedence.
            r_expired <= !done && w_ownerReq && w_timeout;
          end else begin
            r_hold <= r_hold + CW'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= 4'b0000;
          r_busy    <= 1'b0;
          r_expired <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule
